gsim_sweep_sched: RTL
=====================

Name: gsim_sweep_sched

Overview:
- Sequencing controller for the Gauss-Seidel solver datapath: 16 unknowns, one shared multi-cycle PE.
- Runs the whole job: initialise x from b, then ITER sweeps in index order 0..N-1.
- Per index: issue to the PE, wait for completion, write the result back to the x register file.
- After the last sweep, streams x out under a ready/valid handshake.
- Holds no arithmetic: the PE, the x/b storage and the divide-by-20 stay outside this block.

Parameters:
- N, 16, number of unknowns / x entries.
- IDX_W, 4, index width (log2 N).
- ITER, 120, Gauss-Seidel sweeps per job.
- ITER_W, 7, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- init_en  out  1  one-cycle pulse: copy b[] into x[].
- pe_start  out  1  one-cycle PE launch.
- pe_idx  out  IDX_W  index being solved; valid from ISSUE through WB.
- nb_addr  out  6*IDX_W  neighbour addresses {+3,-3,+2,-2,+1,-1}, slot 0 = -1 in the LSBs.
- nb_zero  out  6  per-slot out-of-range flag; the PE must treat that operand as 0.
- pe_done  in  1  PE result valid, one-cycle pulse.
- wb_en  out  1  x write strobe.
- wb_addr  out  IDX_W  x write address (= pe_idx).
- iter_cnt  out  ITER_W  completed sweeps.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output stream ready.
- out_addr  out  IDX_W  x read address for the output stream.
- out_last  out  1  high with out_valid when out_addr == N-1.
- done  out  1  one-cycle pulse after the last output beat.

Behaviour:
- Reset (async assert, synchronous release):
  - State IDLE.
  - All outputs 0; idx, iter_cnt and out counter 0.
- States and transitions:
  - IDLE: start -> INIT.
  - INIT (1 cycle): init_en=1, idx=0, iter_cnt=0 -> ISSUE.
  - ISSUE (1 cycle): pe_start=1 -> WAIT.
  - WAIT: hold until pe_done -> WB. There is no timeout.
  - WB (1 cycle): wb_en=1, wb_addr=idx.
    - If idx==N-1 -> SWEEP_END.
    - Else idx+1 -> ISSUE.
  - SWEEP_END (1 cycle): iter_cnt+1, idx=0.
    - If the new iter_cnt < ITER -> ISSUE.
    - Else -> OUTPUT.
  - OUTPUT: out_valid=1, out_addr=out counter. A beat transfers when out_valid && out_ready.
    - On transfer with out_addr==N-1: done=1 for one cycle, -> IDLE.
    - Otherwise the counter increments.
- Per-element latency: 3 controller cycles + PE latency (pe_start to pe_done).
- Neighbours for idx i, offset d:
  - addr = i+d when 0 <= i+d <= N-1, with nb_zero bit = 0.
  - Otherwise addr = 0 and nb_zero bit = 1.
  - Combinational from idx; stable throughout ISSUE/WAIT/WB.
- Boundary conditions:
  - pe_done outside WAIT is ignored.
  - pe_done in the same cycle as the WAIT entry edge is not possible: pe_start precedes WAIT.
  - start while busy is ignored; no restart.
  - out_ready low holds out_addr and out_valid steady.
  - idx and iter arithmetic is unsigned; idx never wraps past N-1.
  - Reset mid-job aborts immediately to IDLE. No done pulse, and no wb_en after reset.
  - ITER=1 gives exactly one sweep, then OUTPUT.

Optional Feature:
- Macro: GSIM_EARLY_STOP_EN.
- Enabled, added logic:
  - Extra input pe_small (1), sampled with pe_done: |x_new - x_old| below the PE threshold.
  - A sticky flag all_small is set at sweep start and cleared by any pe_small=0.
  - In SWEEP_END, if all_small && iter_cnt+1 >= 2, go to OUTPUT regardless of ITER.
  - Extra output early_stop (1), held high from that point until next start.
- Disabled:
  - Port pe_small and port early_stop are absent.
  - Exactly ITER sweeps always run.

Decomposition:
- Shared package gsim_pkg:
  - State enum (IDLE, INIT, ISSUE, WAIT, WB, SWEEP_END, OUTPUT).
  - N, IDX_W, ITER, ITER_W.
  - Neighbour offset constants {-1,+1,-2,+2,-3,+3}.
- One sub-module, gsim_nbr_gen: combinational idx -> nb_addr/nb_zero. It is reused by the verification model.

Test Plan:
- Reset with start=1 held; release reset, pulse start -> init_en pulses exactly 1 cycle later, busy=1.
- PE model with 4-cycle pe_done latency, ITER=2:
  - Exactly 32 wb_en pulses, wb_addr sequence 0..15 twice.
  - iter_cnt ends at 2; job-done pulse count 1.
- idx=0 -> nb_zero=6'b010101, nb_addr slot +1=1, +2=2, +3=3. idx=15 -> nb_zero=6'b101010, slot -1=14, -3=12.
- OUTPUT with out_ready toggling 1,0,0,1,...:
  - out_addr advances only on handshake; 16 beats total.
  - out_last only on addr 15; done pulses on the cycle after beat 15 is accepted.
- Assert reset (low) during WAIT in sweep 3 -> busy=0 the same cycle, no wb_en afterwards; a new start runs a clean job from idx 0.
- With GSIM_EARLY_STOP_EN, pe_small=1 always, ITER=120 -> OUTPUT after sweep 2, early_stop=1, iter_cnt=2.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel sweep scheduler.
// Holds the problem size, sweep count, FSM state encoding and the
// neighbour offset table used to build the PE operand addresses.
package gsim_pkg;

    localparam int N        = 16;
    localparam int IDX_W    = 4;
    localparam int ITER     = 120;
    localparam int ITER_W   = 7;
    localparam int NB_SLOTS = 6;

    // Neighbour offsets in slot order; slot 0 sits in the LSBs of nb_addr.
    localparam int OFS_M1 = -1;
    localparam int OFS_P1 = 1;
    localparam int OFS_M2 = -2;
    localparam int OFS_P2 = 2;
    localparam int OFS_M3 = -3;
    localparam int OFS_P3 = 3;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT,
        WB,
        SWEEP_END,
        OUTPUT
    } state_t;

    // Slot number -> signed index offset.
    function automatic int nb_offset(input int slot);
        case (slot)
            0:       return OFS_M1;
            1:       return OFS_P1;
            2:       return OFS_M2;
            3:       return OFS_P2;
            4:       return OFS_M3;
            5:       return OFS_P3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/gsim_sweep_sched_if.sv
// PE launch/complete handshake and x output stream of the sweep scheduler.
// master = scheduler side, slave = PE / stream consumer side.
interface gsim_sweep_sched_if;
    import gsim_pkg::*;

    logic                      pe_start;
    logic [IDX_W-1:0]          pe_idx;
    logic [NB_SLOTS*IDX_W-1:0] nb_addr;
    logic [NB_SLOTS-1:0]       nb_zero;
    logic                      pe_done;

    logic                      out_valid;
    logic                      out_ready;
    logic [IDX_W-1:0]          out_addr;
    logic                      out_last;

    modport master (
        output pe_start, pe_idx, nb_addr, nb_zero,
        input  pe_done,
        output out_valid, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  pe_start, pe_idx, nb_addr, nb_zero,
        output pe_done,
        input  out_valid, out_addr, out_last,
        output out_ready
    );

endinterface

// File: rtl/gsim_nbr_gen.sv
// Combinational neighbour address generator: for the current index i it
// produces i+d for d in {-1,+1,-2,+2,-3,+3}. Out-of-range neighbours get
// address 0 and their nb_zero bit set so the PE uses a zero operand.
module gsim_nbr_gen
    import gsim_pkg::*;
(
    input  logic [IDX_W-1:0]          idx,
    output logic [NB_SLOTS*IDX_W-1:0] nb_addr,
    output logic [NB_SLOTS-1:0]       nb_zero
);

    // Two extra bits: one for the sign, one for headroom up to N-1+3.
    localparam int PW = IDX_W + 2;
    localparam logic signed [PW-1:0] POS_MAX = PW'(N - 1);

    for (genvar s = 0; s < NB_SLOTS; s++) begin : g_slot
        localparam logic signed [PW-1:0] OFS = PW'(nb_offset(s));

        logic signed [PW-1:0] pos;

        assign pos        = $signed({2'b00, idx}) + OFS;
        assign nb_zero[s] = pos[PW-1] || (pos > POS_MAX);
        assign nb_addr[s*IDX_W +: IDX_W] = nb_zero[s] ? '0 : pos[IDX_W-1:0];
    end

endmodule

// File: rtl/gsim_sweep_sched.sv
// Gauss-Seidel sweep scheduler: initialises x from b, runs ITER sweeps
// over indices 0..N-1 through one shared multi-cycle PE (issue, wait for
// pe_done, write back), then streams x out under ready/valid.
// Optional build macro GSIM_EARLY_STOP_EN adds pe_small/early_stop and ends
// the job once a whole sweep (from the second sweep on) reports small deltas.
module gsim_sweep_sched
    import gsim_pkg::*;
#(
    parameter int ITER = gsim_pkg::ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              init_en,
    output logic              wb_en,
    output logic [IDX_W-1:0]  wb_addr,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              done,
`ifdef GSIM_EARLY_STOP_EN
    input  logic              pe_small,
    output logic              early_stop,
`endif
    gsim_sweep_sched_if.master bus
);

    localparam logic [ITER_W:0] ITER_LIM = (ITER_W + 1)'(ITER);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          out_cnt;
    logic                      pe_start_q;
    logic                      out_valid_q;
    logic                      out_last_q;

    logic [ITER_W:0]           iter_next;
    logic                      last_idx;
    logic                      last_out;
    logic                      stop_now;
    logic [NB_SLOTS*IDX_W-1:0] nb_addr_w;
    logic [NB_SLOTS-1:0]       nb_zero_w;

    // iter_next carries one spare bit so the compare against ITER never wraps.
    assign iter_next = {1'b0, iter_cnt} + 1'b1;
    assign last_idx  = (idx == IDX_W'(N - 1));
    assign last_out  = (out_cnt == IDX_W'(N - 1));

`ifdef GSIM_EARLY_STOP_EN
    localparam logic [ITER_W:0] MIN_SWEEPS = (ITER_W + 1)'(2);

    logic all_small;
    logic early_hit;

    assign early_hit = all_small && (iter_next >= MIN_SWEEPS);
    assign stop_now  = (iter_next >= ITER_LIM) || early_hit;
`else
    assign stop_now  = (iter_next >= ITER_LIM);
`endif

    gsim_nbr_gen u_nbr_gen (
        .idx     (idx),
        .nb_addr (nb_addr_w),
        .nb_zero (nb_zero_w)
    );

    assign bus.pe_start  = pe_start_q;
    assign bus.pe_idx    = idx;
    assign bus.nb_addr   = nb_addr_w;
    assign bus.nb_zero   = nb_zero_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_cnt;
    assign bus.out_last  = out_last_q;
    assign wb_addr       = idx;

    // Job sequencer: state, counters and all registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            iter_cnt    <= '0;
            out_cnt     <= '0;
            busy        <= 1'b0;
            init_en     <= 1'b0;
            pe_start_q  <= 1'b0;
            wb_en       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done        <= 1'b0;
`ifdef GSIM_EARLY_STOP_EN
            all_small   <= 1'b0;
            early_stop  <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes fall back to 0 unless a state re-asserts them.
            init_en    <= 1'b0;
            pe_start_q <= 1'b0;
            wb_en      <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= INIT;
                        busy     <= 1'b1;
                        init_en  <= 1'b1;
                        idx      <= '0;
                        iter_cnt <= '0;
`ifdef GSIM_EARLY_STOP_EN
                        early_stop <= 1'b0;
`endif
                    end
                end

                INIT: begin
                    state      <= ISSUE;
                    pe_start_q <= 1'b1;
`ifdef GSIM_EARLY_STOP_EN
                    all_small  <= 1'b1;
`endif
                end

                ISSUE: begin
                    state <= WAIT;
                end

                // No timeout: the PE is trusted to answer every launch.
                WAIT: begin
                    if (bus.pe_done) begin
                        state <= WB;
                        wb_en <= 1'b1;
`ifdef GSIM_EARLY_STOP_EN
                        if (!pe_small) begin
                            all_small <= 1'b0;
                        end
`endif
                    end
                end

                WB: begin
                    if (last_idx) begin
                        state <= SWEEP_END;
                    end else begin
                        idx        <= idx + 1'b1;
                        state      <= ISSUE;
                        pe_start_q <= 1'b1;
                    end
                end

                SWEEP_END: begin
                    iter_cnt <= iter_next[ITER_W-1:0];
                    idx      <= '0;
                    if (stop_now) begin
                        state       <= OUTPUT;
                        out_valid_q <= 1'b1;
                        out_cnt     <= '0;
                        out_last_q  <= 1'b0;
`ifdef GSIM_EARLY_STOP_EN
                        early_stop  <= early_hit;
`endif
                    end else begin
                        state      <= ISSUE;
                        pe_start_q <= 1'b1;
`ifdef GSIM_EARLY_STOP_EN
                        all_small  <= 1'b1;
`endif
                    end
                end

                // out_addr/out_valid only move on an accepted beat.
                OUTPUT: begin
                    if (bus.out_ready) begin
                        if (last_out) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_cnt     <= '0;
                        end else begin
                            out_cnt    <= out_cnt + 1'b1;
                            out_last_q <= (out_cnt == IDX_W'(N - 2));
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
